pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 Parameter XLEN taken from the global `XLEN define; all PC ports are XLEN wide.
REQ-003 clk_i  input  1  single clock; every state element updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 flush_i  input  1  backend redirect, for example a mispredict or trap.
REQ-006 flush_pc_i  input  XLEN  backend redirect target.
REQ-007 idu_redirect_i  input  1  decode-stage redirect.
REQ-008 idu_redirect_pc_i  input  XLEN  decode-stage redirect target.
REQ-009 btb_rd_pc_o  output  XLEN  BTB lookup address; equals the current PC register.
REQ-010 btb_rd_predictedpc_i  input  XLEN  BTB predicted target.
REQ-011 btb_rd_groupoffset_i  input  2  slot of the predicted branch within its 16-byte group.
REQ-012 btb_rd_branchtype_i  input  3  predicted branch type.
REQ-013 btb_rd_predictedvalid_i  input  1  BTB tag hit.
REQ-014 fetch_valid_o  output  1  fetch request valid.
REQ-015 fetch_ready_i  input  1  fetch unit accepts the request.
REQ-016 fetch_pc_o  output  XLEN  fetch address.
REQ-017 fetch_taken_o  output  1  a taken prediction applies to this group.
REQ-018 fetch_groupoffset_o  output  2  slot of the predicted branch.
REQ-019 fetch_branchtype_o  output  3  predicted branch type.
REQ-020 fetch_predictedpc_o  output  XLEN  predicted next PC.

Function
REQ-021 FSM states: BOOT, RUN, HOLD.
- BOOT is entered on reset and lasts exactly 1 cycle with fetch_valid_o=0.
- BOOT always moves to RUN.
REQ-022 In RUN, fetch_valid_o=1 unless flush_i or idu_redirect_i is high in the same cycle.
REQ-023 Prediction applies when hit = btb_rd_predictedvalid_i AND (btb_rd_groupoffset_i >= pc[3:2]).
REQ-024 Sequential PC: seq = {pc[XLEN-1:4], 4'b0} + 16, with modulo-2^XLEN wrap.
REQ-025 Next PC on handshake (fetch_valid_o AND fetch_ready_i) = hit ? btb_rd_predictedpc_i : seq.
REQ-026 fetch_taken_o = hit.
REQ-027 fetch_predictedpc_o = the next PC selected in REQ-025.
REQ-028 fetch_groupoffset_o and fetch_branchtype_o pass the BTB values through unchanged.
REQ-029 If valid and not ready, the FSM goes to HOLD.
- The PC register holds.
- All fetch_* outputs stay stable until the handshake.
- The BTB outputs for the held PC are re-registered on entry to HOLD, so the outputs stay stable even if the BTB is written meanwhile.
REQ-030 HOLD returns to RUN on handshake and loads the next PC from the held prediction.
REQ-031 Redirect priority: flush_i > idu_redirect_i > handshake advance > hold.
REQ-032 On flush_i, the PC is loaded with {flush_pc_i[XLEN-1:2], 2'b00} at the next edge.
- The FSM goes to RUN.
- Any pending handshake is dropped.
REQ-033 idu_redirect_i behaves as REQ-032 using idu_redirect_pc_i, and only when flush_i is low.
REQ-034 Latency: the redirect target appears on fetch_pc_o, with fetch_valid_o=1, in the cycle after the redirect.
REQ-035 A redirect in BOOT is honoured: the PC is loaded and BOOT still exits to RUN.
REQ-036 No combinational path from fetch_ready_i to fetch_valid_o.

Reset
REQ-037 With rst_i high at an edge:
- PC <= RESET_PC;
- FSM <= BOOT;
- HOLD capture registers <= 0;
- rst_i overrides flush_i and idu_redirect_i.
REQ-038 While in BOOT, fetch_valid_o=0 and fetch_taken_o=0; reset asserted mid-HOLD abandons the request.

Structure
REQ-039 The FSM state enum and the branch-type encodings (3-bit: NONE, JAL, JALR, BRANCH, CALL, RET) live in the shared prv664 package.
- The same encodings are used by the BTB and the IDU.
REQ-040 The group size constant (16 bytes, 4 slots) lives in the same package.
REQ-041 No sub-module; the BTB is instantiated by the parent alongside pc_gen.

Verification
REQ-042 Reset: release rst_i -> one cycle fetch_valid_o=0, then fetch_pc_o=0x8000_0000 with valid=1.
REQ-043 Sequential fetch: ready=1, no BTB hit, start at 0x8000_0004 -> PCs 0x8000_0004, 0x8000_0010, 0x8000_0020.
REQ-044 BTB hit: pc=0x8000_0010, hit with offset 2, target 0x8000_1000 -> fetch_taken_o=1, next PC 0x8000_1000.
- Same case with pc=0x8000_0018 and offset 1 -> not taken, next PC 0x8000_0020.
REQ-045 Backpressure: ready low for 3 cycles while the BTB entry is rewritten -> fetch_* outputs unchanged for all 3 cycles, advance after ready.
REQ-046 Simultaneous flush_i (0x8000_2002) and idu_redirect_i (0x8000_3000) during HOLD -> next fetch_pc_o=0x8000_2000, valid=1.
REQ-047 Wrap: pc=0xFFFF_FFFF_FFFF_FFF0, no hit -> next PC 0x0.

Source files
------------

// File: rtl/prv664_pkg.sv
// ---------------------------------------------------------------------------
// prv664_pkg
// Shared definitions for the prv664 front end.
//   - fetch-group geometry (16-byte groups, four 4-byte slots)
//   - PC generator FSM state encoding
//   - branch-type encoding, shared by the BTB, the PC generator and the IDU
//   - small PC arithmetic helpers used wherever a group-relative address
//     has to be formed
// No ports; import with "import prv664_pkg::*;".
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 64
`endif

package prv664_pkg;

  localparam int PC_W = `XLEN;

  // Fetch group geometry: one fetch request covers an aligned 16-byte group
  // made of four 32-bit instruction slots.
  localparam int GROUP_BYTES = 16;
  localparam int GROUP_SLOTS = 4;
  localparam int SLOT_BYTES  = GROUP_BYTES / GROUP_SLOTS;
  localparam int SLOT_LSB    = $clog2(SLOT_BYTES);
  localparam int SLOT_W      = $clog2(GROUP_SLOTS);
  localparam int GROUP_LSB   = SLOT_LSB + SLOT_W;

  localparam int BRANCH_TYPE_W = 3;

  // PC generator control states.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } pc_gen_state_e;

  // Branch classification carried alongside predictions and decode results.
  typedef enum logic [BRANCH_TYPE_W-1:0] {
    NONE   = 3'd0,
    JAL    = 3'd1,
    JALR   = 3'd2,
    BRANCH = 3'd3,
    CALL   = 3'd4,
    RET    = 3'd5
  } branch_type_e;

  // Base address of the fetch group containing pc.
  function automatic logic [PC_W-1:0] group_base(input logic [PC_W-1:0] pc);
    return pc & ~PC_W'(GROUP_BYTES - 1);
  endfunction

  // Start of the next sequential group; wraps naturally at 2^PC_W.
  function automatic logic [PC_W-1:0] seq_pc(input logic [PC_W-1:0] pc);
    return group_base(pc) + PC_W'(GROUP_BYTES);
  endfunction

  // Redirect targets are forced onto a slot boundary.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return pc & ~PC_W'(SLOT_BYTES - 1);
  endfunction

endpackage

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen
// Front-end PC generator. Holds the current fetch PC, presents it to the BTB
// for lookup, and issues one fetch request per 16-byte group. The next PC is
// either the BTB target (when the predicted branch lies at or after the
// current slot) or the next sequential group. Backend flushes and decode
// redirects override the sequential/predicted flow, flush first.
//
// Ports
//   clk_i                    clock, all state updates on its rising edge
//   rst_i                    synchronous active-high reset
//   flush_i / flush_pc_i     backend redirect and its target
//   idu_redirect_i / _pc_i   decode-stage redirect and its target
//   btb_rd_pc_o              BTB lookup address (current PC)
//   btb_rd_predictedpc_i     BTB predicted target
//   btb_rd_groupoffset_i     slot of the predicted branch in its group
//   btb_rd_branchtype_i      predicted branch type
//   btb_rd_predictedvalid_i  BTB tag hit
//   fetch_valid_o            fetch request valid
//   fetch_ready_i            fetch unit accepts the request
//   fetch_pc_o               fetch address
//   fetch_taken_o            a taken prediction applies to this group
//   fetch_groupoffset_o      slot of the predicted branch
//   fetch_branchtype_o       predicted branch type
//   fetch_predictedpc_o      PC that will be fetched after this group
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 64
`endif

module pc_gen
  import prv664_pkg::*;
#(
  parameter int               XLEN     = `XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,

  input  logic                     flush_i,
  input  logic [XLEN-1:0]          flush_pc_i,
  input  logic                     idu_redirect_i,
  input  logic [XLEN-1:0]          idu_redirect_pc_i,

  output logic [XLEN-1:0]          btb_rd_pc_o,
  input  logic [XLEN-1:0]          btb_rd_predictedpc_i,
  input  logic [SLOT_W-1:0]        btb_rd_groupoffset_i,
  input  logic [BRANCH_TYPE_W-1:0] btb_rd_branchtype_i,
  input  logic                     btb_rd_predictedvalid_i,

  output logic                     fetch_valid_o,
  input  logic                     fetch_ready_i,
  output logic [XLEN-1:0]          fetch_pc_o,
  output logic                     fetch_taken_o,
  output logic [SLOT_W-1:0]        fetch_groupoffset_o,
  output logic [BRANCH_TYPE_W-1:0] fetch_branchtype_o,
  output logic [XLEN-1:0]          fetch_predictedpc_o
);

  pc_gen_state_e state_q;
  pc_gen_state_e state_d;

  logic [XLEN-1:0]          pc_q;

  logic                     hold_taken_q;
  logic [SLOT_W-1:0]        hold_offset_q;
  logic [BRANCH_TYPE_W-1:0] hold_type_q;
  logic [XLEN-1:0]          hold_pred_q;

  logic                     redirect;
  logic                     handshake;
  logic                     live_hit;
  logic [XLEN-1:0]          live_next_pc;
  logic                     enter_hold;

  assign redirect = flush_i | idu_redirect_i;

  // A BTB entry only matters if its branch sits at or after the slot we
  // start fetching from; an earlier slot is skipped by this fetch.
  assign live_hit = btb_rd_predictedvalid_i &&
                    (btb_rd_groupoffset_i >= pc_q[GROUP_LSB-1:SLOT_LSB]);
  assign live_next_pc = live_hit ? btb_rd_predictedpc_i : seq_pc(pc_q);

  // fetch_valid_o depends only on state and redirects, never on
  // fetch_ready_i, so the handshake cannot form a combinational loop.
  assign handshake  = fetch_valid_o & fetch_ready_i;
  assign enter_hold = (state_q == RUN) && fetch_valid_o && !fetch_ready_i;

  assign btb_rd_pc_o = pc_q;
  assign fetch_pc_o  = pc_q;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. BOOT always lasts one cycle, even if a redirect
  // arrives then; a redirect from any state lands in RUN so the new target
  // is requested immediately.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect) begin
          state_d = RUN;
        end else if (fetch_valid_o && !fetch_ready_i) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect || handshake) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // Output logic. In HOLD the prediction comes from the copy captured when
  // the request first stalled, so a BTB update during the stall cannot
  // change a request the fetch unit has already seen.
  always_comb begin
    fetch_valid_o       = 1'b0;
    fetch_taken_o       = 1'b0;
    fetch_groupoffset_o = btb_rd_groupoffset_i;
    fetch_branchtype_o  = btb_rd_branchtype_i;
    fetch_predictedpc_o = live_next_pc;
    case (state_q)
      BOOT: begin
        fetch_valid_o = 1'b0;
        fetch_taken_o = 1'b0;
      end
      RUN: begin
        fetch_valid_o = !redirect;
        fetch_taken_o = live_hit;
      end
      HOLD: begin
        fetch_valid_o       = !redirect;
        fetch_taken_o       = hold_taken_q;
        fetch_groupoffset_o = hold_offset_q;
        fetch_branchtype_o  = hold_type_q;
        fetch_predictedpc_o = hold_pred_q;
      end
      default: begin
        fetch_valid_o = 1'b0;
        fetch_taken_o = 1'b0;
      end
    endcase
  end

  // PC register. Priority: reset, flush, decode redirect, accepted request.
  // Without any of these the PC simply holds (stall or BOOT).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else if (flush_i) begin
      pc_q <= align_pc(flush_pc_i);
    end else if (idu_redirect_i) begin
      pc_q <= align_pc(idu_redirect_pc_i);
    end else if (handshake) begin
      pc_q <= fetch_predictedpc_o;
    end
  end

  // Snapshot of the live prediction, taken on the cycle the request first
  // fails to be accepted. Later stall cycles keep the snapshot untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_taken_q  <= 1'b0;
      hold_offset_q <= '0;
      hold_type_q   <= '0;
      hold_pred_q   <= '0;
    end else if (enter_hold) begin
      hold_taken_q  <= live_hit;
      hold_offset_q <= btb_rd_groupoffset_i;
      hold_type_q   <= btb_rd_branchtype_i;
      hold_pred_q   <= live_next_pc;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen
// Directed scenarios followed by randomized traffic for pc_gen. Expected
// outputs come from a behavioural model of the fetch rules kept here: the
// current PC, whether the boot cycle is pending, and a snapshot of the
// request that is waiting to be accepted.
// ---------------------------------------------------------------------------
module tb_pc_gen;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic [63:0] flush_pc_i;
  logic        idu_redirect_i;
  logic [63:0] idu_redirect_pc_i;
  logic [63:0] btb_rd_pc_o;
  logic [63:0] btb_rd_predictedpc_i;
  logic [1:0]  btb_rd_groupoffset_i;
  logic [2:0]  btb_rd_branchtype_i;
  logic        btb_rd_predictedvalid_i;
  logic        fetch_valid_o;
  logic        fetch_ready_i;
  logic [63:0] fetch_pc_o;
  logic        fetch_taken_o;
  logic [1:0]  fetch_groupoffset_o;
  logic [2:0]  fetch_branchtype_o;
  logic [63:0] fetch_predictedpc_o;

  always #5 clk_i = ~clk_i;

  pc_gen dut (
    .clk_i                   (clk_i),
    .rst_i                   (rst_i),
    .flush_i                 (flush_i),
    .flush_pc_i              (flush_pc_i),
    .idu_redirect_i          (idu_redirect_i),
    .idu_redirect_pc_i       (idu_redirect_pc_i),
    .btb_rd_pc_o             (btb_rd_pc_o),
    .btb_rd_predictedpc_i    (btb_rd_predictedpc_i),
    .btb_rd_groupoffset_i    (btb_rd_groupoffset_i),
    .btb_rd_branchtype_i     (btb_rd_branchtype_i),
    .btb_rd_predictedvalid_i (btb_rd_predictedvalid_i),
    .fetch_valid_o           (fetch_valid_o),
    .fetch_ready_i           (fetch_ready_i),
    .fetch_pc_o              (fetch_pc_o),
    .fetch_taken_o           (fetch_taken_o),
    .fetch_groupoffset_o     (fetch_groupoffset_o),
    .fetch_branchtype_o      (fetch_branchtype_o),
    .fetch_predictedpc_o     (fetch_predictedpc_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit          m_boot = 1'b1;
  logic [63:0] m_pc   = RESET_PC;
  bit          m_held = 1'b0;
  bit          m_h_taken;
  logic [1:0]  m_h_off;
  logic [2:0]  m_h_type;
  logic [63:0] m_h_pred;

  // Expected outputs for the current cycle.
  bit          e_valid;
  bit          e_taken;
  logic [1:0]  e_off;
  logic [2:0]  e_type;
  logic [63:0] e_pred;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Derive this cycle's expected request from the model and current inputs.
  task automatic computeExpected();
    int slot;
    e_valid = !m_boot && !flush_i && !idu_redirect_i;
    if (m_held) begin
      e_taken = m_h_taken;
      e_off   = m_h_off;
      e_type  = m_h_type;
      e_pred  = m_h_pred;
    end else begin
      slot    = int'((m_pc % 64'd16) / 64'd4);
      e_taken = btb_rd_predictedvalid_i && (int'(btb_rd_groupoffset_i) >= slot);
      e_off   = btb_rd_groupoffset_i;
      e_type  = btb_rd_branchtype_i;
      e_pred  = e_taken ? btb_rd_predictedpc_i : (m_pc / 64'd16) * 64'd16 + 64'd16;
    end
    if (m_boot) e_taken = 1'b0;
  endtask

  // Drive one cycle's inputs just after the falling edge.
  task automatic applyStimulus(input bit rst, input bit fl, input logic [63:0] fpc,
                               input bit idu, input logic [63:0] ipc, input bit bv,
                               input logic [1:0] boff, input logic [2:0] btype,
                               input logic [63:0] btgt, input bit rdy);
    @(negedge clk_i);
    rst_i                   = rst;
    flush_i                 = fl;
    flush_pc_i              = fpc;
    idu_redirect_i          = idu;
    idu_redirect_pc_i       = ipc;
    btb_rd_predictedvalid_i = bv;
    btb_rd_groupoffset_i    = boff;
    btb_rd_branchtype_i     = btype;
    btb_rd_predictedpc_i    = btgt;
    fetch_ready_i           = rdy;
    #1;
  endtask

  task automatic checkOutput();
    computeExpected();
    check("fetch_pc", fetch_pc_o, m_pc);
    check("btb_rd_pc", btb_rd_pc_o, m_pc);
    check("fetch_valid", 64'(fetch_valid_o), 64'(e_valid));
    if (m_boot) check("boot_taken", 64'(fetch_taken_o), 64'd0);
    if (e_valid) begin
      check("fetch_taken", 64'(fetch_taken_o), 64'(e_taken));
      check("fetch_groupoffset", 64'(fetch_groupoffset_o), 64'(e_off));
      check("fetch_branchtype", 64'(fetch_branchtype_o), 64'(e_type));
      check("fetch_predictedpc", fetch_predictedpc_o, e_pred);
    end
  endtask

  // Clock edge: update the model with the rules applied to this cycle.
  task automatic advance();
    computeExpected();
    @(posedge clk_i);
    if (rst_i) begin
      m_pc = RESET_PC; m_boot = 1'b1; m_held = 1'b0;
    end else if (flush_i) begin
      m_pc = flush_pc_i & ~64'd3; m_boot = 1'b0; m_held = 1'b0;
    end else if (idu_redirect_i) begin
      m_pc = idu_redirect_pc_i & ~64'd3; m_boot = 1'b0; m_held = 1'b0;
    end else if (e_valid && fetch_ready_i) begin
      m_pc = e_pred; m_held = 1'b0;
    end else begin
      if (e_valid && !m_held) begin
        m_held = 1'b1;
        m_h_taken = e_taken; m_h_off = e_off; m_h_type = e_type; m_h_pred = e_pred;
      end
      m_boot = 1'b0;
    end
    #1;
  endtask

  // Plain running cycle: ready, no BTB hit, no redirect.
  task automatic idleCycle();
    applyStimulus(0, 0, 64'd0, 0, 64'd0, 0, 2'd0, 3'd0, 64'd0, 1);
    checkOutput();
    advance();
  endtask

  initial begin
    // Reset; state is unknown before the first edge, so skip that check.
    applyStimulus(1, 0, 64'd0, 0, 64'd0, 0, 2'd0, 3'd0, 64'd0, 1);
    advance();
    applyStimulus(1, 1, 64'h1234, 1, 64'h5678, 0, 2'd0, 3'd0, 64'd0, 1);
    checkOutput();
    advance();

    // Boot cycle then first fetch at the reset PC.
    applyStimulus(0, 0, 64'd0, 0, 64'd0, 0, 2'd0, 3'd0, 64'd0, 1);
    checkOutput();
    check("boot_valid_low", 64'(fetch_valid_o), 64'd0);
    advance();
    applyStimulus(0, 0, 64'd0, 0, 64'd0, 0, 2'd0, 3'd0, 64'd0, 1);
    checkOutput();
    check("reset_pc", fetch_pc_o, 64'h8000_0000);
    check("reset_valid", 64'(fetch_valid_o), 64'd1);
    advance();

    // Sequential fetch from a mid-group start.
    applyStimulus(0, 0, 64'd0, 1, 64'h8000_0004, 0, 2'd0, 3'd0, 64'd0, 1);
    checkOutput();
    advance();
    applyStimulus(0, 0, 64'd0, 0, 64'd0, 0, 2'd0, 3'd0, 64'd0, 1);
    check("seq_pc0", fetch_pc_o, 64'h8000_0004);
    checkOutput();
    advance();
    applyStimulus(0, 0, 64'd0, 0, 64'd0, 0, 2'd0, 3'd0, 64'd0, 1);
    check("seq_pc1", fetch_pc_o, 64'h8000_0010);
    checkOutput();
    advance();
    applyStimulus(0, 0, 64'd0, 0, 64'd0, 0, 2'd0, 3'd0, 64'd0, 1);
    check("seq_pc2", fetch_pc_o, 64'h8000_0020);
    checkOutput();
    advance();

    // BTB hit at offset 2 from slot 0.
    applyStimulus(0, 0, 64'd0, 1, 64'h8000_0010, 0, 2'd0, 3'd0, 64'd0, 1);
    checkOutput();
    advance();
    applyStimulus(0, 0, 64'd0, 0, 64'd0, 1, 2'd2, 3'd4, 64'h8000_1000, 1);
    checkOutput();
    check("hit_taken", 64'(fetch_taken_o), 64'd1);
    check("hit_pred", fetch_predictedpc_o, 64'h8000_1000);
    check("hit_type", 64'(fetch_branchtype_o), 64'd4);
    advance();
    applyStimulus(0, 0, 64'd0, 0, 64'd0, 0, 2'd0, 3'd0, 64'd0, 1);
    check("hit_next_pc", fetch_pc_o, 64'h8000_1000);
    checkOutput();
    advance();

    // Branch slot lies before the starting slot: not taken.
    applyStimulus(0, 0, 64'd0, 1, 64'h8000_0018, 0, 2'd0, 3'd0, 64'd0, 1);
    checkOutput();
    advance();
    applyStimulus(0, 0, 64'd0, 0, 64'd0, 1, 2'd1, 3'd3, 64'h8000_1000, 1);
    checkOutput();
    check("early_slot_taken", 64'(fetch_taken_o), 64'd0);
    check("early_slot_pred", fetch_predictedpc_o, 64'h8000_0020);
    advance();

    // Backpressure with the BTB rewritten during the stall.
    applyStimulus(0, 0, 64'd0, 0, 64'd0, 1, 2'd3, 3'd3, 64'h8000_4000, 0);
    check("stall_pc", fetch_pc_o, 64'h8000_0020);
    checkOutput();
    advance();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 64'd0, 0, 64'd0, 0, 2'd1, 3'd1, 64'hDEAD_0000, (i == 2) ? 1'b1 : 1'b0);
      checkOutput();
      check("hold_pc", fetch_pc_o, 64'h8000_0020);
      check("hold_taken", 64'(fetch_taken_o), 64'd1);
      check("hold_off", 64'(fetch_groupoffset_o), 64'd3);
      check("hold_type", 64'(fetch_branchtype_o), 64'd3);
      check("hold_pred", fetch_predictedpc_o, 64'h8000_4000);
      advance();
    end
    applyStimulus(0, 0, 64'd0, 0, 64'd0, 0, 2'd0, 3'd0, 64'd0, 1);
    check("hold_release_pc", fetch_pc_o, 64'h8000_4000);
    checkOutput();
    advance();

    // Flush and decode redirect together while stalled.
    applyStimulus(0, 0, 64'd0, 0, 64'd0, 0, 2'd0, 3'd0, 64'd0, 0);
    checkOutput();
    advance();
    applyStimulus(0, 1, 64'h8000_2002, 1, 64'h8000_3000, 0, 2'd0, 3'd0, 64'd0, 1);
    checkOutput();
    check("redirect_valid_low", 64'(fetch_valid_o), 64'd0);
    advance();
    applyStimulus(0, 0, 64'd0, 0, 64'd0, 0, 2'd0, 3'd0, 64'd0, 1);
    check("flush_priority_pc", fetch_pc_o, 64'h8000_2000);
    check("flush_valid", 64'(fetch_valid_o), 64'd1);
    checkOutput();
    advance();

    // Sequential wrap at the top of the address space.
    applyStimulus(0, 1, 64'hFFFF_FFFF_FFFF_FFF0, 0, 64'd0, 0, 2'd0, 3'd0, 64'd0, 1);
    checkOutput();
    advance();
    applyStimulus(0, 0, 64'd0, 0, 64'd0, 0, 2'd0, 3'd0, 64'd0, 1);
    checkOutput();
    check("wrap_pred", fetch_predictedpc_o, 64'd0);
    advance();
    applyStimulus(0, 0, 64'd0, 0, 64'd0, 0, 2'd0, 3'd0, 64'd0, 1);
    check("wrap_pc", fetch_pc_o, 64'd0);
    checkOutput();
    advance();

    // Reset in the middle of a stall abandons the request.
    applyStimulus(0, 0, 64'd0, 0, 64'd0, 0, 2'd0, 3'd0, 64'd0, 0);
    checkOutput();
    advance();
    applyStimulus(1, 0, 64'd0, 0, 64'd0, 0, 2'd0, 3'd0, 64'd0, 0);
    checkOutput();
    advance();
    applyStimulus(0, 0, 64'd0, 0, 64'd0, 0, 2'd0, 3'd0, 64'd0, 1);
    checkOutput();
    check("rst_hold_valid", 64'(fetch_valid_o), 64'd0);
    advance();
    idleCycle();

    // Redirect during the boot cycle.
    applyStimulus(1, 0, 64'd0, 0, 64'd0, 0, 2'd0, 3'd0, 64'd0, 1);
    checkOutput();
    advance();
    applyStimulus(0, 0, 64'd0, 1, 64'h8000_7003, 0, 2'd0, 3'd0, 64'd0, 1);
    checkOutput();
    advance();
    applyStimulus(0, 0, 64'd0, 0, 64'd0, 0, 2'd0, 3'd0, 64'd0, 1);
    check("boot_redirect_pc", fetch_pc_o, 64'h8000_7000);
    check("boot_redirect_valid", 64'(fetch_valid_o), 64'd1);
    checkOutput();
    advance();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      applyStimulus($urandom_range(0, 39) == 0,
                    $urandom_range(0, 9) == 0, {$urandom, $urandom},
                    $urandom_range(0, 9) == 0, {$urandom, $urandom},
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    3'($urandom_range(0, 7)), {$urandom, $urandom},
                    $urandom_range(0, 3) != 0);
      checkOutput();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
